// File: rtl/my_ram8_pkg.sv
// Shared types and constants for the 8 x 16-bit register memory.
package my_ram8_pkg;

  localparam int DEPTH = 8;

  typedef logic [15:0] word_t;
  typedef logic [2:0]  addr_t;

  typedef enum logic {
    IDLE,
    CLEAR
  } state_t;

endpackage

// File: rtl/my_dmux8way.sv
// One-bit 1-to-8 demultiplexer: routes in_i to the output selected by sel_i.
module my_dmux8way
  import my_ram8_pkg::*;
(
  input  logic       in_i,
  input  addr_t      sel_i,
  output logic [7:0] out_o
);

  always_comb begin
    out_o        = '0;
    out_o[sel_i] = in_i;
  end

endmodule

// File: rtl/my_mux8way16.sv
// 16-bit 8-to-1 multiplexer.
module my_mux8way16
  import my_ram8_pkg::*;
(
  input  logic [7:0][15:0] data_i,
  input  addr_t            sel_i,
  output word_t            out_o
);

  assign out_o = data_i[sel_i];

endmodule

// File: rtl/my_register16.sv
// 16-bit load-enable register with a companion valid bit.
module my_register16
  import my_ram8_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  load_i,
  input  word_t data_i,
  input  logic  valid_i,
  output word_t data_o,
  output logic  valid_o
);

  word_t data_q;
  logic  valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else if (load_i) begin
      data_q  <= data_i;
      valid_q <= valid_i;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/my_ram8.sv
// 8 x 16-bit register memory with per-word valid flags and a clear sweep.
// Optional write-through forwarding when RAM8_BYPASS_EN is defined.
module my_ram8
  import my_ram8_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] in,
  input  logic        load,
  input  logic [2:0]  address,
  input  logic        clr,
  output logic [15:0] out,
  output logic        valid,
  output logic        busy
);

  state_t state_q, state_d;
  addr_t  cnt_q, cnt_d;

  logic             wrStrobe;
  addr_t            wrAddr;
  word_t            wrData;
  logic             wrValid;
  logic [7:0]       weVec;
  logic [7:0][15:0] wordVec;
  logic [7:0]       validVec;
  word_t            muxOut;

  assign busy = (state_q == CLEAR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (clr) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // The sweep borrows the write port; clr wins over a same-cycle load.
  assign wrStrobe = busy | (load & ~clr);
  assign wrAddr   = busy ? cnt_q : address;
  assign wrData   = busy ? '0 : in;
  assign wrValid  = ~busy;

  my_dmux8way u_dmux (
    .in_i  (wrStrobe),
    .sel_i (wrAddr),
    .out_o (weVec)
  );

  for (genvar i = 0; i < DEPTH; i++) begin : g_word
    my_register16 u_reg (
      .clk     (clk),
      .rst_n   (rst_n),
      .load_i  (weVec[i]),
      .data_i  (wrData),
      .valid_i (wrValid),
      .data_o  (wordVec[i]),
      .valid_o (validVec[i])
    );
  end

  my_mux8way16 u_mux (
    .data_i (wordVec),
    .sel_i  (address),
    .out_o  (muxOut)
  );

`ifdef RAM8_BYPASS_EN
  logic fwd;
  assign fwd   = rst_n & load & ~busy & ~clr;
  assign out   = fwd ? in : muxOut;
  assign valid = fwd | validVec[address];
`else
  assign out   = muxOut;
  assign valid = validVec[address];
`endif

endmodule

// File: tb/tb_my_ram8.sv
// Self-checking bench for my_ram8: queue-based reference model plus directed literals.
module tb_my_ram8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] dataIn = '0;
  logic        load = 1'b0;
  logic [2:0]  address = '0;
  logic        clr = 1'b0;
  logic [15:0] dataOut;
  logic        valid;
  logic        busy;

  int compareCount = 0;
  int failCount = 0;

  my_ram8 dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .in      (dataIn),
    .load    (load),
    .address (address),
    .clr     (clr),
    .out     (dataOut),
    .valid   (valid),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  // Reference model: contents, valid flags and a queue of words still to sweep.
  logic [15:0] modelMem [8];
  logic        modelVld [8];
  int          sweepQ [$];
  int          sweepAddr;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) begin
        modelMem[i] = '0;
        modelVld[i] = 1'b0;
      end
      sweepQ.delete();
    end else if (sweepQ.size() != 0) begin
      sweepAddr = sweepQ.pop_front();
      modelMem[sweepAddr] = '0;
      modelVld[sweepAddr] = 1'b0;
    end else if (clr) begin
      for (int i = 0; i < 8; i++) sweepQ.push_back(i);
    end else if (load) begin
      modelMem[address] = dataIn;
      modelVld[address] = 1'b1;
    end
  end

  // Every falling edge: the DUT outputs must match the model.
  always @(negedge clk) begin
    logic [15:0] expOut;
    logic        expValid;
    logic        expBusy;
    expBusy  = (sweepQ.size() != 0);
    expOut   = modelMem[address];
    expValid = modelVld[address];
`ifdef RAM8_BYPASS_EN
    if (rst_n && load && !clr && !expBusy) begin
      expOut   = dataIn;
      expValid = 1'b1;
    end
`endif
    compareCount += 3;
    if (dataOut !== expOut) begin
      failCount++;
      $display("[TB] FAIL model_out t=%0t addr=%0d got %h want %h", $time, address, dataOut, expOut);
    end
    if (valid !== expValid) begin
      failCount++;
      $display("[TB] FAIL model_valid t=%0t addr=%0d got %b want %b", $time, address, valid, expValid);
    end
    if (busy !== expBusy) begin
      failCount++;
      $display("[TB] FAIL model_busy t=%0t got %b want %b", $time, busy, expBusy);
    end
  end

  task automatic applyStimulus(input logic ld, input logic cl, input logic [2:0] addr,
                               input logic [15:0] data);
    @(posedge clk);
    #1;
    load    = ld;
    clr     = cl;
    address = addr;
    dataIn  = data;
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [15:0] expOut,
                             input logic expValid, input logic expBusy);
    compareCount += 3;
    if (dataOut !== expOut) begin
      failCount++;
      $display("[TB] FAIL %s out got %h want %h", name, dataOut, expOut);
    end
    if (valid !== expValid) begin
      failCount++;
      $display("[TB] FAIL %s valid got %b want %b", name, valid, expValid);
    end
    if (busy !== expBusy) begin
      failCount++;
      $display("[TB] FAIL %s busy got %b want %b", name, busy, expBusy);
    end
  endtask

  task automatic checkInt(input string name, input int act, input int exp);
    compareCount++;
    if (act != exp) begin
      failCount++;
      $display("[TB] FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic fillWords();
    for (int k = 0; k < 8; k++) applyStimulus(1'b1, 1'b0, 3'(k), 16'(16'h1111 * (k + 1)));
    applyStimulus(1'b0, 1'b0, 3'd0, 16'h0000);
  endtask

  initial begin
    int busyCycles;
    bit done;

    // Power-up reset, released mid-cycle.
    #12;
    checkOutput("reset_init", 16'h0000, 1'b0, 1'b0);
    rst_n = 1'b1;

    applyStimulus(1'b0, 1'b0, 3'd2, 16'h0000);
    checkOutput("unwritten_word", 16'h0000, 1'b0, 1'b0);

    fillWords();
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1'b0, 1'b0, 3'(k), 16'h0000);
      checkOutput($sformatf("readback_%0d", k), 16'(16'h1111 * (k + 1)), 1'b1, 1'b0);
    end

    // Same-address back-to-back writes keep the last value.
    applyStimulus(1'b1, 1'b0, 3'd1, 16'hAAAA);
    applyStimulus(1'b1, 1'b0, 3'd1, 16'h5555);
    applyStimulus(1'b0, 1'b0, 3'd1, 16'h0000);
    checkOutput("b2b_same_addr", 16'h5555, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 3'd1, 16'h2222);

    // Clear sweep watched on word 7, with load/clr pokes while busy.
    applyStimulus(1'b0, 1'b1, 3'd7, 16'h0000);
    busyCycles = 0;
    done = 0;
    for (int i = 0; i < 12 && !done; i++) begin
      @(posedge clk);
      #2;
      if (busy) begin
        busyCycles++;
        checkOutput("sweep_word7_old", 16'h8888, 1'b1, 1'b1);
        load    = 1'b1;
        clr     = 1'b1;
        address = 3'd7;
        dataIn  = 16'hDEAD;
      end else begin
        done    = 1;
        load    = 1'b0;
        clr     = 1'b0;
        address = 3'd7;
      end
    end
    #1;
    checkInt("sweep_terminated", int'(done), 1);
    checkInt("busy_cycles", busyCycles, 8);
    checkOutput("sweep_word7_cleared", 16'h0000, 1'b0, 1'b0);
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1'b0, 1'b0, 3'(k), 16'h0000);
      checkOutput($sformatf("swept_%0d", k), 16'h0000, 1'b0, 1'b0);
    end

    applyStimulus(1'b1, 1'b0, 3'd0, 16'h1234);
    applyStimulus(1'b0, 1'b0, 3'd0, 16'h0000);
    checkOutput("first_load_after_sweep", 16'h1234, 1'b1, 1'b0);

    // Simultaneous clr + load: the load is dropped.
    applyStimulus(1'b1, 1'b0, 3'd3, 16'h3333);
    applyStimulus(1'b1, 1'b1, 3'd3, 16'hBEEF);
    applyStimulus(1'b0, 1'b0, 3'd3, 16'h0000);
    checkOutput("clr_load_no_write", 16'h3333, 1'b1, 1'b1);
    done = 0;
    for (int i = 0; i < 12 && !done; i++) begin
      applyStimulus(1'b0, 1'b0, 3'd3, 16'h0000);
      if (!busy) done = 1;
    end
    checkInt("sweep2_terminated", int'(done), 1);
    checkOutput("clr_load_word3", 16'h0000, 1'b0, 1'b0);

    // Reset in the middle of a sweep.
    fillWords();
    applyStimulus(1'b0, 1'b1, 3'd7, 16'h0000);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 3'd7, 16'h0000);
    checkOutput("mid_sweep_old", 16'h8888, 1'b1, 1'b1);
    load   = 1'b1;
    dataIn = 16'hCAFE;
    rst_n  = 1'b0;
    #1;
    for (int k = 0; k < 8; k++) begin
      address = 3'(k);
      #0.1;
      checkOutput($sformatf("reset_mid_%0d", k), 16'h0000, 1'b0, 1'b0);
    end
    load = 1'b0;
    #1;
    rst_n = 1'b1;
    applyStimulus(1'b1, 1'b0, 3'd6, 16'h6666);
    applyStimulus(1'b0, 1'b0, 3'd6, 16'h0000);
    checkOutput("write_after_reset", 16'h6666, 1'b1, 1'b0);

    // Same-cycle visibility of a pending write.
    applyStimulus(1'b1, 1'b0, 3'd5, 16'hA5A5);
`ifdef RAM8_BYPASS_EN
    checkOutput("bypass_same_cycle", 16'hA5A5, 1'b1, 1'b0);
`else
    checkOutput("no_bypass_old", 16'h0000, 1'b0, 1'b0);
`endif
    applyStimulus(1'b0, 1'b0, 3'd5, 16'h0000);
    checkOutput("write5_stored", 16'hA5A5, 1'b1, 1'b0);

    @(posedge clk);
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] timeout");
  end

endmodule
